// File: rtl/riscv_pkg.sv
// Shared types and constants for the register-file writeback path.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int STARVE_W   = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE1 = 1'b1
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rf_starve_ctr.sv
// Counts consecutive denied cycles of the low-priority writeback port and
// flags the cycle in which the count reaches the starvation limit.
module rf_starve_ctr
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  logic [STARVE_W-1:0] count;
  logic [STARVE_W-1:0] count_inc;

  assign count_inc = sat_inc(count);
  assign limit_hit = inc && (count_inc == STARVE_W'(STARVE_LIMIT));

  // Clear has priority so a grant or a withdrawn request always restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline WB stage
// (port 0, fixed priority) and the multi-cycle unit (port 1), with a
// starvation guard that forces one grant to port 1. Write outputs are
// registered, so a request accepted at edge N is written by reg_file at N+1.
module rf_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [REG_ADDR_W-1:0] wb0_rd,
  input  logic [XLEN-1:0]       wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [REG_ADDR_W-1:0] wb1_rd,
  input  logic [XLEN-1:0]       wb1_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       regf_write_data,
  output logic                  last_src,
  output logic                  forced
);

  arb_state_e state;
  arb_state_e state_next;
  logic       wb0_xfer;
  logic       wb1_xfer;
  logic       starve_inc;
  logic       starve_clr;
  logic       starve_hit;
  wb_req_t    grant_req;

  assign wb0_xfer   = wb0_valid && wb0_ready;
  assign wb1_xfer   = wb1_valid && wb1_ready;
  assign starve_inc = (state == NORMAL) && wb1_valid && !wb1_ready;
  assign starve_clr = !wb1_valid || wb1_xfer;

  rf_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .limit_hit(starve_hit)
  );

  // State register; reset returns to fixed-priority operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Ready depends only on state and valids; held low while reset is asserted.
  always_comb begin
    wb0_ready = 1'b0;
    wb1_ready = 1'b0;
    forced    = 1'b0;
    if (!rst) begin
      case (state)
        NORMAL: begin
          wb0_ready = 1'b1;
          wb1_ready = !wb0_valid;
        end
        FORCE1: begin
          wb1_ready = 1'b1;
          forced    = 1'b1;
        end
        default: begin
          wb0_ready = 1'b0;
          wb1_ready = 1'b0;
        end
      endcase
    end
  end

  // FORCE1 lasts until port 1 is served or withdraws its request.
  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (starve_hit) state_next = FORCE1;
      FORCE1:  if (wb1_xfer || !wb1_valid) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  // Mux the granted request; the two transfers are mutually exclusive.
  always_comb begin
    grant_req = '{rd: wb0_rd, data: wb0_data};
    if (wb1_xfer) begin
      grant_req = '{rd: wb1_rd, data: wb1_data};
    end
  end

  // Register the write; x0 writes are accepted but never enable reg_file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write       <= 1'b0;
      rd_addr         <= '0;
      regf_write_data <= '0;
      last_src        <= 1'b0;
    end else if (wb0_xfer || wb1_xfer) begin
      reg_write       <= (grant_req.rd != '0);
      rd_addr         <= grant_req.rd;
      regf_write_data <= grant_req.data;
      last_src        <= wb1_xfer;
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule
